// File: rtl/ext_req_initiator.sv
// ext_req_initiator: 4-phase req/ack initiator issuing `count` handshakes with optional ack timeout.
// Define INITIATOR_TRACE_EN for simulation-only per-handshake and timeout trace output.
module ext_req_initiator #(
    parameter int CNT_W = 8,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [TMO_W-1:0] timeout,
    output logic             req,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] calls_done
);
    typedef enum logic [2:0] {IDLE, ASSERT, RELEASE, FINISH, ABORT} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, calls_q, calls_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, wait_q, wait_d;
    logic req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;
        calls_d = calls_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // busy_q still high here on the done/err cycle, so a start then is ignored
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    busy_d  = 1'b1;
                    calls_d = '0;
                    if (count != '0) begin
                        cnt_d   = count;
                        tmo_d   = timeout;
                        wait_d  = '0;
                        req_d   = 1'b1;
                        state_d = ASSERT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ASSERT: begin
                if (ack) begin
                    calls_d = calls_q + CNT_W'(1);
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end else if (tmo_q != '0 && wait_q == tmo_q - TMO_W'(1)) begin
                    req_d   = 1'b0;
                    state_d = ABORT;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            RELEASE: begin
                if (!ack) begin
                    if (calls_q == cnt_q) begin
                        state_d = FINISH;
                    end else begin
                        wait_d  = '0;
                        req_d   = 1'b1;
                        state_d = ASSERT;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                if (!ack) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            wait_q  <= '0;
            calls_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
            calls_q <= calls_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
`ifdef INITIATOR_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && state_q == ASSERT && ack)
            $display("ext_req_initiator: call %0d ack wait %0d", calls_q + CNT_W'(1), wait_q);
        if (rst_n && state_q == ASSERT && state_d == ABORT)
            $display("ext_req_initiator: req timeout");
    end
`endif
    assign req        = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign calls_done = calls_q;
endmodule

// File: tb/tb_ext_req_initiator.sv
// tb_ext_req_initiator: scoreboard bench for ext_req_initiator with a mode-selectable responder.
module tb_ext_req_initiator;
    localparam int CNT_W = 8;
    localparam int TMO_W = 8;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [TMO_W-1:0] timeout = '0;
    logic req, busy, done, err;
    logic [CNT_W-1:0] calls_done;
    int n_chk = 0, n_err = 0, cyc = 0, start_cyc = 0, mode = 0, hcnt = 0, hc = 0;
    typedef struct {
        logic is_err;
        int   calls;
        int   lat;
    } exp_t;
    exp_t sb[$];

    ext_req_initiator #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .timeout(timeout),
        .req(req), .ack(ack), .busy(busy), .done(done), .err(err), .calls_done(calls_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // responder modes: 0 echo, 1 silent, 2 ack on 4th req-high edge and hold 2 cycles, 3 stuck high
    always @(posedge clk) begin
        case (mode)
            0: ack <= req;
            1: ack <= 1'b0;
            2: begin
                if (req) begin
                    hc   <= 0;
                    hcnt <= hcnt + 1;
                    if (hcnt >= 3) ack <= 1'b1;
                end else begin
                    hcnt <= 0;
                    if (ack) begin
                        hc <= hc + 1;
                        if (hc == 1) begin
                            ack <= 1'b0;
                            hc  <= 0;
                        end
                    end
                end
            end
            default: ack <= 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            chk("excl", {31'd0, done && err}, 0);
            if (sb.size() == 0) begin
                chk("spurious", {30'd0, done, err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("kind", {31'd0, err}, {31'd0, e.is_err});
                chk("calls", {24'd0, calls_done}, e.calls);
                chk("lat", cyc - start_cyc - 1, e.lat);
            end
        end
    end

    task automatic run(input int c, input int t, input logic e_err, input int e_calls, input int e_lat);
        count     = CNT_W'(c);
        timeout   = TMO_W'(t);
        start     = 1'b1;
        start_cyc = cyc;
        sb.push_back('{is_err: e_err, calls: e_calls, lat: e_lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_calls", {24'd0, calls_done}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 0;
        run(3, 0, 1'b0, 3, 13);
        for (int k = 0; k < 13; k++) begin
            chk("echo_req", {31'd0, req}, {31'd0, k < 12 && (k % 4) < 2});
            chk("echo_busy", {31'd0, busy}, 1);
            @(negedge clk);
        end
        drain();
        chk("echo_hold", {24'd0, calls_done}, 3);

        run(0, 0, 1'b0, 0, 0);
        chk("zero_busy", {31'd0, busy}, 1);
        chk("zero_req", {31'd0, req}, 0);
        chk("zero_calls", {24'd0, calls_done}, 0);
        @(negedge clk);
        chk("zero_busy1", {31'd0, busy}, 0);
        chk("zero_done1", {31'd0, done}, 0);
        drain();

        mode = 1;
        run(2, 3, 1'b1, 0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("tmo_req", {31'd0, req}, {31'd0, k < 3});
            @(negedge clk);
        end
        drain();
        chk("tmo_calls", {24'd0, calls_done}, 0);

        mode = 2;
        run(2, 5, 1'b0, 2, 17);
        for (int k = 0; k < 10; k++) begin
            chk("dly_req", {31'd0, req}, {31'd0, k < 5 || k >= 8});
            @(negedge clk);
        end
        drain();
        chk("dly_calls", {24'd0, calls_done}, 2);

        mode = 0;
        repeat (2) @(negedge clk);
        run(1, 0, 1'b0, 1, 5);
        count = CNT_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("dup_calls", {24'd0, calls_done}, 1);
        mode = 3;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ack_req", {31'd0, req}, 0);
            chk("idle_ack_busy", {31'd0, busy}, 0);
        end
        mode = 0;
        repeat (3) @(negedge clk);

        count = CNT_W'(4);
        timeout = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_req", {31'd0, req}, 1);
        chk("pre_rst_calls", {24'd0, calls_done}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, req}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_calls", {24'd0, calls_done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 0);
        run(2, 0, 1'b0, 2, 9);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ext_req_initiator.md
Name: ext_req_initiator

Overview:
Initiator side of the single-bit 4-phase req/ack handshake used by embedded external modules. It issues `count` sequential requests to one responder and counts completed handshakes. An optional per-request ack timeout aborts the run, and the block reports done or err to the calling thread. It sits between a generated datapath thread (start/done) and one external responder (req/ack).

Parameters:
CNT_W, 8, width of request count and completed-call counter
TMO_W, 8, width of timeout value and wait counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a run (sampled only in IDLE)
count  in  CNT_W  number of handshakes in the run; sampled with start
timeout  in  TMO_W  max cycles req waits for ack; 0 = no timeout; sampled with start
req  out  1  request to responder
ack  in  1  acknowledge from responder (level; may echo req one cycle late)
busy  out  1  high from the cycle after an accepted start until the done/err cycle, inclusive
done  out  1  one-cycle pulse; run completed normally
err  out  1  one-cycle pulse; run aborted on timeout
calls_done  out  CNT_W  handshakes completed in current/last run

Behaviour:
- Reset (async assert, sync release): state=IDLE; req=0, busy=0, done=0, err=0, calls_done=0, internal counters 0. Reset mid-run drops req immediately and returns to IDLE; no done/err pulse.
- All outputs are registered.
- IDLE:
  - start=1 and count!=0: latch count and timeout, clear calls_done, go to ASSERT; req=1 and busy=1 from the next cycle.
  - start=1 and count==0: done pulses next cycle with busy=1 for that cycle only; req stays 0; calls_done=0.
  - ack is ignored in IDLE.
- ASSERT (req=1): wait counter starts at 0 on entry and increments each cycle ack=0.
  - ack=1 sampled: calls_done+1, go to RELEASE, req=0 next cycle.
  - Else if timeout!=0 and wait counter == timeout-1: go to ABORT, req=0 next cycle.
  - ack has priority over timeout in the same cycle.
- RELEASE (req=0): wait for ack=0 with no timeout.
  - On ack=0 sampled: if calls_done==latched count, go to FINISH; else go to ASSERT (req=1 next cycle).
- FINISH: done=1 for one cycle, busy=1, then IDLE with busy=0.
- ABORT (req=0): wait for ack=0, then err=1 for one cycle and go to IDLE.
- start while busy: ignored, with no effect on latched values.
- Per-call cadence against a responder doing ack<=req: req high 2 cycles, low 2 cycles. A run of N calls takes 4N+1 cycles from the start edge to the done pulse.
- calls_done holds its value after done/err until the next accepted start.
- Widths: calls_done never wraps, since count <= 2^CNT_W-1. Wait counter compares in TMO_W bits.
- done and err are never high together.

Optional Feature:
INITIATOR_TRACE_EN
- Defined: simulation-only display on each completed handshake, printing the call index and the ack wait cycles. On abort it prints "req timeout". Synthesizable logic is unchanged.
- Undefined: no display statements are compiled; behaviour is identical.

Test Plan:
- Echo responder (ack<=req), start with count=3, timeout=0 → req pattern 1,1,0,0 three times; done pulse at cycle 13 after the start edge; calls_done=3; err never set.
- start with count=0 → done the next cycle, req never asserts, calls_done=0, busy high for 1 cycle.
- Responder never acks, count=2, timeout=3 → req high exactly 3 cycles, then 0; err pulse once; calls_done=0; no done.
- Responder acks after a 5-cycle delay with timeout=5, and ack holds 2 cycles after req drops → no abort, since ack on the last cycle beats timeout; RELEASE waits for ack low before the next req; calls_done=1 per call.
- start pulsed again while busy (count=1 run), plus ack high in IDLE → second start ignored, exactly one handshake, done once; idle ack causes no state change.
- rst_n low mid-ASSERT with count=4 → req, busy and calls_done go to 0 asynchronously; no done/err; a new start after release runs normally.
